// File: rtl/tdm_demux8_pkg.sv
// Shared TDM link definitions: slot count, slot-select width, and frame-alignment FSM encodings.
// Imported by both the demux top and its slot counter.
package tdm_demux8_pkg;
    localparam int TDM_NSLOT = 8;
    localparam int TDM_SEL_W = 3;

    typedef enum logic {
        TDM_HUNT = 1'b0,
        TDM_LOCK = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: 3-bit wrap, sync load-to-1 has priority over enable; last flag at count 7.
// Latency: one cycle from enable/load to new count; no backpressure.
module tdm_slot_ctr
    import tdm_demux8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load1,
    output logic [TDM_SEL_W-1:0] cnt,
    output logic                 last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= TDM_SEL_W'(1);
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == TDM_SEL_W'(TDM_NSLOT - 1));
endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM demux: serial slot samples into a parallel frame, aligned to a slot-0 sync marker.
// Latency: frame published one cycle after its slot-7 beat; no backpressure, 1 sample/cycle.
// Optional TDM_DEMUX_FRAMECNT_EN adds a 16-bit wrapping completed-frame counter port.
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sync,
    output logic [TDM_NSLOT*WIDTH-1:0] out_data,
    output logic                     out_valid,
    output logic [TDM_SEL_W-1:0]     out_sel,
    output logic                     sync_err
`ifdef TDM_DEMUX_FRAMECNT_EN
    ,
    output logic [15:0]              frame_cnt
`endif
);
    tdm_state_t       state;
    logic [WIDTH-1:0] shadow [TDM_NSLOT-1];
    logic             last;
    logic             locked;
    logic             realign;
    logic             complete;

    assign locked   = (state == TDM_LOCK);
    // A sync landing anywhere but slot 0 restarts the frame instead of completing it.
    assign realign  = in_valid & locked & in_sync & (out_sel != '0);
    assign complete = in_valid & locked & last & ~realign;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid & locked),
        .load1 (in_valid & in_sync),
        .cnt   (out_sel),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TDM_HUNT;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            for (int k = 0; k < TDM_NSLOT - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            out_valid <= complete;
            sync_err  <= realign;
            if (in_valid) begin
                if (in_sync) begin
                    state     <= TDM_LOCK;
                    shadow[0] <= in_data;
                end else if (locked && !last) begin
                    shadow[out_sel] <= in_data;
                end
            end
            if (complete) begin
                for (int k = 0; k < TDM_NSLOT - 1; k++) begin
                    out_data[k*WIDTH +: WIDTH] <= shadow[k];
                end
                out_data[(TDM_NSLOT-1)*WIDTH +: WIDTH] <= in_data;
            end
        end
    end

`ifdef TDM_DEMUX_FRAMECNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (complete) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif
endmodule
